// File: rtl/run_checkpoint_checker.sv
// Run-time self-check unit for the pipelined MIPS core: counts cycles from a start pulse,
// stops on a cycle number and/or PC match, then compares snapshotted probes with expected values.
module run_checkpoint_checker #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [CNT_WIDTH-1:0]      stop_cycle,
   input  logic [WIDTH-1:0]          stop_pc,
   input  logic [WIDTH-1:0]          pc_in,
   input  logic [CHANNELS*WIDTH-1:0] probe_data,
   input  logic [CHANNELS*WIDTH-1:0] expect_data,
   input  logic [CHANNELS-1:0]       check_mask,
   output logic [CNT_WIDTH-1:0]      cycle,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [CHANNELS-1:0]       fail_mask,
   output logic [WIDTH-1:0]          captured_pc
);

   typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

   state_e                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      cycle_q;
   logic [1:0]                mode_q;
   logic [CNT_WIDTH-1:0]      stop_cycle_q;
   logic [WIDTH-1:0]          stop_pc_q;
   logic [CHANNELS*WIDTH-1:0] expect_q;
   logic [CHANNELS-1:0]       check_mask_q;
   logic [CHANNELS*WIDTH-1:0] snap_q;
   logic                      pass_q;
   logic                      timeout_q;
   logic [CHANNELS-1:0]       fail_mask_q;
   logic [WIDTH-1:0]          captured_pc_q;

   logic [CNT_WIDTH-1:0]      stop_target;
   logic                      cycle_hit;
   logic                      pc_hit;
   logic                      stop_event;
   logic                      timeout_hit;
   logic [CHANNELS-1:0]       fail_d;

   // A zero stop cycle would never be reached since counting starts at 1.
   assign stop_target = (stop_cycle_q == '0) ? CNT_WIDTH'(1) : stop_cycle_q;
   assign cycle_hit   = (cycle_q == stop_target);
   assign pc_hit      = (pc_in == stop_pc_q);
   assign timeout_hit = (cycle_q == CNT_WIDTH'(TIMEOUT));

   always_comb begin
      stop_event = cycle_hit;
      case (mode_q)
         2'd1:    stop_event = pc_hit;
         2'd2:    stop_event = cycle_hit | pc_hit;
         default: stop_event = cycle_hit;
      endcase
   end

   always_comb begin
      fail_d = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         fail_d[i] = check_mask_q[i] & (snap_q[i*WIDTH +: WIDTH] != expect_q[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (start) state_d = StRun;
         StRun: begin
            if (stop_event) begin
               state_d = StCheck;
            end else if (timeout_hit) begin
               state_d = StDone;
            end
         end
         StCheck: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StRun) || (state_q == StCheck);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q       <= '0;
         mode_q        <= '0;
         stop_cycle_q  <= '0;
         stop_pc_q     <= '0;
         expect_q      <= '0;
         check_mask_q  <= '0;
         snap_q        <= '0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         fail_mask_q   <= '0;
         captured_pc_q <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  mode_q       <= mode;
                  stop_cycle_q <= stop_cycle;
                  stop_pc_q    <= stop_pc;
                  expect_q     <= expect_data;
                  check_mask_q <= check_mask;
                  cycle_q      <= CNT_WIDTH'(1);
                  pass_q       <= 1'b0;
                  timeout_q    <= 1'b0;
                  fail_mask_q  <= '0;
               end
            end
            StRun: begin
               // A stop event coinciding with the timeout cycle wins.
               if (stop_event) begin
                  snap_q        <= probe_data;
                  captured_pc_q <= pc_in;
               end else if (timeout_hit) begin
                  timeout_q     <= 1'b1;
                  pass_q        <= 1'b0;
                  fail_mask_q   <= '0;
                  captured_pc_q <= pc_in;
               end else if (cycle_q != '1) begin
                  cycle_q <= cycle_q + CNT_WIDTH'(1);
               end
            end
            StCheck: begin
               fail_mask_q <= fail_d;
               pass_q      <= ~|fail_d;
            end
            default: ;
         endcase
      end
   end

   assign cycle       = cycle_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign fail_mask   = fail_mask_q;
   assign captured_pc = captured_pc_q;

endmodule

// File: tb/tb_run_checkpoint_checker.sv
// Directed bench for run_checkpoint_checker: table of stop scenarios plus reset / start corner cases.
module tb_run_checkpoint_checker;

   localparam int unsigned W  = 32;
   localparam int unsigned CH = 2;
   localparam int unsigned CW = 32;
   localparam int unsigned TO = 20;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [1:0]      mode;
   logic [CW-1:0]   stop_cycle;
   logic [W-1:0]    stop_pc;
   logic [W-1:0]    pc_in;
   logic [CH*W-1:0] probe_data;
   logic [CH*W-1:0] expect_data;
   logic [CH-1:0]   check_mask;
   logic [CW-1:0]   cycle;
   logic            busy;
   logic            done;
   logic            pass;
   logic            timeout;
   logic [CH-1:0]   fail_mask;
   logic [W-1:0]    captured_pc;

   run_checkpoint_checker #(
      .WIDTH    (W),
      .CHANNELS (CH),
      .CNT_WIDTH(CW),
      .TIMEOUT  (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .stop_cycle (stop_cycle),
      .stop_pc    (stop_pc),
      .pc_in      (pc_in),
      .probe_data (probe_data),
      .expect_data(expect_data),
      .check_mask (check_mask),
      .cycle      (cycle),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout),
      .fail_mask  (fail_mask),
      .captured_pc(captured_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] stop_cycle;
      logic [31:0] stop_pc;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [1:0]  mask;
      int          lat;
      logic [31:0] cyc;
      logic        pass;
      logic        tmo;
      logic [1:0]  fm;
      logic [31:0] cpc;
   } vec_t;

   vec_t vecs[12];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // pc_in during run cycle k is 800 + 4*(k-1); probes fixed at ch0=10, ch1=20.
   task automatic run_vec(input int idx, input vec_t v);
      int k;
      int lat;
      mode        = v.mode;
      stop_cycle  = v.stop_cycle;
      stop_pc     = v.stop_pc;
      expect_data = {v.exp1, v.exp0};
      check_mask  = v.mask;
      start       = 1'b1;
      step();
      start       = 1'b0;
      k           = 1;
      pc_in       = 32'd800;
      // Live config changes after start must be ignored.
      mode        = 2'd1;
      stop_cycle  = 32'd2;
      stop_pc     = 32'd804;
      expect_data = ~expect_data;
      check_mask  = ~check_mask;
      lat         = 0;
      for (int n = 1; n <= 60; n++) begin
         step();
         k++;
         pc_in = 32'd800 + 32'(4 * (k - 1));
         if (done) begin
            lat = n;
            break;
         end
      end
      check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
      check($sformatf("v%0d_cycle", idx), 64'(cycle), 64'(v.cyc));
      check($sformatf("v%0d_pass", idx), 64'(pass), 64'(v.pass));
      check($sformatf("v%0d_timeout", idx), 64'(timeout), 64'(v.tmo));
      check($sformatf("v%0d_fail_mask", idx), 64'(fail_mask), 64'(v.fm));
      check($sformatf("v%0d_captured_pc", idx), 64'(captured_pc), 64'(v.cpc));
      check($sformatf("v%0d_busy", idx), 64'(busy), 64'd0);
   endtask

   initial begin
      //          mode  stop_cyc stop_pc  exp0    exp1    mask  lat cyc    pass  tmo   fm     cpc
      vecs[0]  = '{2'd0, 32'd8,  32'd0,   32'd10, 32'd20, 2'b11, 9, 32'd8,  1'b1, 1'b0, 2'b00, 32'd828};
      vecs[1]  = '{2'd0, 32'd8,  32'd0,   32'd10, 32'd21, 2'b11, 9, 32'd8,  1'b0, 1'b0, 2'b10, 32'd828};
      vecs[2]  = '{2'd0, 32'd8,  32'd0,   32'd10, 32'd21, 2'b01, 9, 32'd8,  1'b1, 1'b0, 2'b00, 32'd828};
      vecs[3]  = '{2'd1, 32'd0,  32'd820, 32'd10, 32'd20, 2'b11, 7, 32'd6,  1'b1, 1'b0, 2'b00, 32'd820};
      vecs[4]  = '{2'd2, 32'd3,  32'd900, 32'd10, 32'd20, 2'b11, 4, 32'd3,  1'b1, 1'b0, 2'b00, 32'd808};
      vecs[5]  = '{2'd1, 32'd0,  32'd900, 32'd10, 32'd20, 2'b11, 20, 32'd20, 1'b0, 1'b1, 2'b00, 32'd876};
      vecs[6]  = '{2'd0, 32'd0,  32'd0,   32'd10, 32'd20, 2'b11, 2, 32'd1,  1'b1, 1'b0, 2'b00, 32'd800};
      vecs[7]  = '{2'd3, 32'd5,  32'd800, 32'd10, 32'd20, 2'b11, 6, 32'd5,  1'b1, 1'b0, 2'b00, 32'd816};
      vecs[8]  = '{2'd2, 32'd10, 32'd812, 32'd10, 32'd20, 2'b11, 5, 32'd4,  1'b1, 1'b0, 2'b00, 32'd812};
      vecs[9]  = '{2'd0, 32'd20, 32'd0,   32'd10, 32'd20, 2'b11, 21, 32'd20, 1'b1, 1'b0, 2'b00, 32'd876};
      vecs[10] = '{2'd0, 32'd2,  32'd0,   32'd5,  32'd6,  2'b00, 3, 32'd2,  1'b1, 1'b0, 2'b00, 32'd804};
      vecs[11] = '{2'd0, 32'd4,  32'd0,   32'd11, 32'd20, 2'b11, 5, 32'd4,  1'b0, 1'b0, 2'b01, 32'd812};

      rst         = 1'b1;
      start       = 1'b0;
      mode        = 2'd0;
      stop_cycle  = '0;
      stop_pc     = '0;
      pc_in       = '0;
      probe_data  = {32'd20, 32'd10};
      expect_data = '0;
      check_mask  = '0;
      step();
      step();
      rst = 1'b0;
      check("reset_cycle", 64'(cycle), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_pass", 64'(pass), 64'd0);
      check("reset_timeout", 64'(timeout), 64'd0);
      check("reset_fail_mask", 64'(fail_mask), 64'd0);
      check("reset_captured_pc", 64'(captured_pc), 64'd0);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Reset mid-run at cycle 5 clears everything.
      mode        = 2'd0;
      stop_cycle  = 32'd10;
      expect_data = {32'd20, 32'd10};
      check_mask  = 2'b11;
      start       = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("rst_run_cycle5", 64'(cycle), 64'd5);
      check("rst_run_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_run_cycle", 64'(cycle), 64'd0);
      check("rst_run_busy", 64'(busy), 64'd0);
      check("rst_run_done", 64'(done), 64'd0);
      check("rst_run_pass", 64'(pass), 64'd0);
      check("rst_run_captured_pc", 64'(captured_pc), 64'd0);
      step();
      check("rst_run_stays_idle", 64'(busy), 64'd0);

      // Start pulsed while in CHECK is ignored.
      pc_in      = 32'd1234;
      stop_cycle = 32'd3;
      start      = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("chk_cycle3", 64'(cycle), 64'd3);
      step();
      check("chk_in_check_busy", 64'(busy), 64'd1);
      check("chk_in_check_done", 64'(done), 64'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("chk_done", 64'(done), 64'd1);
      check("chk_cycle", 64'(cycle), 64'd3);
      check("chk_pass", 64'(pass), 64'd1);
      check("chk_captured_pc", 64'(captured_pc), 64'd1234);
      step();
      check("chk_done_hold", 64'(done), 64'd1);
      check("chk_cycle_hold", 64'(cycle), 64'd3);

      // Start in DONE begins a new run.
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_cycle", 64'(cycle), 64'd1);
      check("restart_done", 64'(done), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      check("restart_pass", 64'(pass), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
